// File: rtl/rgb_stream_packer.sv
// ---------------------------------------------------------------------------
// rgb_stream_packer
//
// Packs a 24-bit RGB pixel stream (valid/ready with sof/eol sideband) into
// 32-bit AXI4-Stream words. Four pixels become three words. A line that ends
// part-way through a word is flushed with a partial tkeep. Pixel bytes enter
// the byte stream low byte first: P[7:0], P[15:8], P[23:16].
//
// An output word FIFO absorbs downstream backpressure; the pixel side only
// stalls through in_stream_ready, which is registered from the FIFO
// occupancy and guarantees room for two words (the most one pixel can push).
//
// Optional feature macro: PACKER_STATS_EN
//   When defined, adds frame_count (accepted sof pixels, wraps) and
//   align_err_count (sof accepted with phase != 0, saturating).
//
// Parameters
//   FIFO_DEPTH     output word FIFO entries (power of 2, >= 2)
//   ERR_CNT_WIDTH  width of the statistics counters
//
// Ports
//   aclk               stream clock
//   aresetn            asynchronous reset, active-high
//   r, g, b            pixel colour, pixel P = {r,g,b}
//   valid              pixel valid
//   sof                first pixel of frame (qualified by valid)
//   eol                last pixel of line (qualified by valid)
//   in_stream_ready    pixel accepted when valid && in_stream_ready
//   out_stream_tdata   packed bytes
//   out_stream_tkeep   byte enables
//   out_stream_tlast   last word of line
//   out_stream_tuser   first word of frame
//   out_stream_tvalid  word valid
//   out_stream_tready  downstream accept
//   frame_count        frames started        (PACKER_STATS_EN only)
//   align_err_count    misaligned sof events (PACKER_STATS_EN only)
// ---------------------------------------------------------------------------
module rgb_stream_packer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
`ifdef PACKER_STATS_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] frame_count,
    output logic [ERR_CNT_WIDTH-1:0] align_err_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Catch illegal configurations at elaboration time.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rgb_stream_packer: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (ERR_CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("rgb_stream_packer: ERR_CNT_WIDTH must be >= 1");
    end

    // FIFO entry layout: {tuser, tlast, tkeep[3:0], tdata[31:0]}
    localparam int EW = 38;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    // -----------------------------------------------------------------------
    // Packing state
    // -----------------------------------------------------------------------
    phase_t      phase;
    phase_t      phase_nxt;
    logic [23:0] residue;
    logic [23:0] residue_nxt;
    logic        pend_user;
    logic        pend_user_nxt;

    logic [23:0] pixel;
    logic        accept;
    phase_t      eff_phase;
    logic        user_eff;

    // Up to two words pushed per accepted pixel.
    logic [1:0]  npush;
    logic [EW-1:0] word0;
    logic [EW-1:0] word1;

    // -----------------------------------------------------------------------
    // Output FIFO state
    // -----------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          ready_nxt;
    logic          pop;
    logic [EW-1:0] head;

    assign pixel  = {r, g, b};
    assign accept = valid & in_stream_ready;

    // A sof pixel always starts a fresh word; any stale residue is dropped.
    assign eff_phase = sof ? PH0 : phase;

    // -----------------------------------------------------------------------
    // Phase FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            phase     <= PH0;
            residue   <= '0;
            pend_user <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            residue   <= residue_nxt;
            pend_user <= pend_user_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Phase FSM: next state and word assembly
    // -----------------------------------------------------------------------
    always_comb begin
        phase_nxt     = phase;
        residue_nxt   = residue;
        pend_user_nxt = pend_user;
        user_eff      = 1'b0;
        npush         = 2'd0;
        word0         = '0;
        word1         = '0;

        if (accept) begin
            user_eff = pend_user | sof;
            unique case (eff_phase)
                PH0: begin
                    if (eol) begin
                        // Whole pixel is the line: three residue bytes.
                        word0 = {user_eff, 1'b1, 4'h7, 8'h00, pixel};
                        npush = 2'd1;
                    end else begin
                        residue_nxt = pixel;
                        phase_nxt   = PH1;
                    end
                end
                PH1: begin
                    word0 = {user_eff, 1'b0, 4'hF, pixel[7:0], residue[23:0]};
                    npush = 2'd1;
                    if (eol) begin
                        word1 = {1'b0, 1'b1, 4'h3, 16'h0000, pixel[23:8]};
                        npush = 2'd2;
                    end else begin
                        residue_nxt = {8'h00, pixel[23:8]};
                        phase_nxt   = PH2;
                    end
                end
                PH2: begin
                    word0 = {user_eff, 1'b0, 4'hF, pixel[15:0], residue[15:0]};
                    npush = 2'd1;
                    if (eol) begin
                        word1 = {1'b0, 1'b1, 4'h1, 24'h000000, pixel[23:16]};
                        npush = 2'd2;
                    end else begin
                        residue_nxt = {16'h0000, pixel[23:16]};
                        phase_nxt   = PH3;
                    end
                end
                PH3: begin
                    // Word boundary lines up with the pixel: nothing left over.
                    word0       = {user_eff, eol, 4'hF, pixel, residue[7:0]};
                    npush       = 2'd1;
                    residue_nxt = '0;
                    phase_nxt   = PH0;
                end
                default: begin
                    phase_nxt = PH0;
                end
            endcase

            if (eol) begin
                phase_nxt   = PH0;
                residue_nxt = '0;
            end

            // tuser stays armed until a word actually leaves the packer.
            pend_user_nxt = user_eff & (npush == 2'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO control
    // -----------------------------------------------------------------------
    assign out_stream_tvalid = (count != '0);
    assign pop               = out_stream_tvalid & out_stream_tready;
    assign count_nxt         = count + CW'(npush) - CW'(pop);

    // Ready looks ahead at next occupancy so that, whenever it is high, the
    // FIFO has room for the two-word worst case of the pixel in flight.
    assign ready_nxt = ((DEPTH_C - count_nxt) >= CW'(2));

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            in_stream_ready <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr + AW'(npush);
            rd_ptr          <= rd_ptr + AW'(pop);
            count           <= count_nxt;
            in_stream_ready <= ready_nxt;
        end
    end

    // Storage carries data only; pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (npush != 2'd0) begin
            mem[wr_ptr] <= word0;
        end
        if (npush == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= word1;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage: head of FIFO, forced to zero when empty
    // -----------------------------------------------------------------------
    assign head = out_stream_tvalid ? mem[rd_ptr] : '0;

    assign out_stream_tdata = head[31:0];
    assign out_stream_tkeep = head[35:32];
    assign out_stream_tlast = head[36];
    assign out_stream_tuser = head[37];

`ifdef PACKER_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
    logic sof_acc;
    logic align_err;

    assign sof_acc   = accept & sof;
    assign align_err = sof_acc & (phase != PH0);

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            frame_count     <= '0;
            align_err_count <= '0;
        end else begin
            if (sof_acc) begin
                frame_count <= frame_count + ERR_CNT_WIDTH'(1);
            end
            if (align_err && (align_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
                align_err_count <= align_err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rgb_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_rgb_stream_packer
//
// Directed bench for rgb_stream_packer. Pixels are driven just after the
// rising edge, outputs are sampled on the falling edge, and every word
// accepted downstream is collected into a queue for comparison against
// hand-computed words or a byte-stream model (pixel bytes low first).
// ---------------------------------------------------------------------------
module tb_rgb_stream_packer;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
`ifdef PACKER_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] align_err_count;
`endif

    int applied;
    int miscompares;
    int sof_cnt;

    // Collected words: {tuser, tlast, tkeep, tdata}
    logic [37:0] q[$];
    // Model byte stream
    logic [7:0]  mb[$];

    rgb_stream_packer #(
        .FIFO_DEPTH   (4),
        .ERR_CNT_WIDTH(16)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .r                (r),
        .g                (g),
        .b                (b),
        .valid            (valid),
        .sof              (sof),
        .eol              (eol),
        .in_stream_ready  (in_stream_ready),
        .out_stream_tdata (out_stream_tdata),
        .out_stream_tkeep (out_stream_tkeep),
        .out_stream_tlast (out_stream_tlast),
        .out_stream_tuser (out_stream_tuser),
        .out_stream_tvalid(out_stream_tvalid),
        .out_stream_tready(out_stream_tready)
`ifdef PACKER_STATS_EN
        ,
        .frame_count      (frame_count),
        .align_err_count  (align_err_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Inputs only change just after the rising edge, so what is seen here
    // is exactly what the next rising edge will act on.
    always @(negedge aclk) begin
        if (!aresetn && out_stream_tvalid && out_stream_tready) begin
            q.push_back({out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one pixel until accepted; returns at rising edge + 1.
    task automatic send_px(input logic [23:0] p, input bit s, input bit e);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        {r, g, b} = p;
        valid = 1'b1;
        sof = s;
        eol = e;
        while (!done) begin
            @(negedge aclk);
            done = in_stream_ready;
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 300) begin
                applied++;
                miscompares++;
                $display("FAIL send_px_timeout: pixel %06h not accepted, ready=%0b required 1", p, in_stream_ready);
                done = 1'b1;
            end
        end
        if (s) sof_cnt++;
        valid = 1'b0;
        sof = 1'b0;
        eol = 1'b0;
    endtask

    // Wait (bounded) for at least n collected words, then a few idle cycles
    // so that any extra words would also be collected.
    task automatic wait_words(input int n, output bit ok);
        int k;
        k = 0;
        while (q.size() < n && k < 400) begin
            @(negedge aclk);
            k++;
        end
        ok = (q.size() >= n);
        repeat (6) @(negedge aclk);
        @(posedge aclk);
        #1;
    endtask

    task automatic model_px(input logic [23:0] p);
        mb.push_back(p[7:0]);
        mb.push_back(p[15:8]);
        mb.push_back(p[23:16]);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        applied++;
        if ({out_stream_tvalid, out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, in_stream_ready} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b data=%08h keep=%h last=%0b user=%0b ready=%0b required all 0",
                     out_stream_tvalid, out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, in_stream_ready);
        end
`ifdef PACKER_STATS_EN
        applied++;
        if (frame_count !== 16'd0 || align_err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stats: frame=%0d align=%0d required 0 0", frame_count, align_err_count);
        end
`endif
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        applied++;
        if (in_stream_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_release: got %0b required 0 (registered)", in_stream_ready);
        end
        @(negedge aclk);
        applied++;
        if (in_stream_ready !== 1'b1 || out_stream_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_idle: ready=%0b tvalid=%0b required 1 0", in_stream_ready, out_stream_tvalid);
        end
        @(posedge aclk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_four_pixels();
        logic [37:0] exp [3];
        logic [37:0] got;
        bit ok;
        exp[0] = {1'b1, 1'b0, 4'hF, 32'h66112233};
        exp[1] = {1'b0, 1'b0, 4'hF, 32'h88994455};
        exp[2] = {1'b0, 1'b0, 4'hF, 32'hAABBCC77};
        q.delete();
        out_stream_tready = 1'b1;
        send_px(24'h112233, 1'b1, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b0);
        send_px(24'hAABBCC, 1'b0, 1'b0);
        wait_words(3, ok);
        applied++;
        if (q.size() != 3) begin
            miscompares++;
            $display("FAIL four_px_count: got %0d words required 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 38'h0;
            applied++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL four_px_word%0d: got %010h required %010h", i, got, exp[i]);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_short_lines();
        logic [37:0] exp [10];
        logic [37:0] got;
        bit ok;
        // Two pixels, eol on the second: two-byte flush.
        exp[0] = {1'b0, 1'b0, 4'hF, 32'h66112233};
        exp[1] = {1'b0, 1'b1, 4'h3, 32'h00004455};
        // Restart at PH0 with a single eol pixel.
        exp[2] = {1'b0, 1'b1, 4'h7, 32'h00778899};
        // Three pixels, eol on the third: one-byte flush.
        exp[3] = {1'b0, 1'b0, 4'hF, 32'h66112233};
        exp[4] = {1'b0, 1'b0, 4'hF, 32'h88994455};
        exp[5] = {1'b0, 1'b1, 4'h1, 32'h00000077};
        // Four pixels, eol on the fourth: no flush word, tlast on PH3 word.
        exp[6] = {1'b0, 1'b0, 4'hF, 32'h66112233};
        exp[7] = {1'b0, 1'b0, 4'hF, 32'h88994455};
        exp[8] = {1'b0, 1'b1, 4'hF, 32'hAABBCC77};
        // Single pixel with sof and eol.
        exp[9] = {1'b1, 1'b1, 4'h7, 32'h00112233};
        q.delete();
        out_stream_tready = 1'b1;
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b1);
        send_px(24'h778899, 1'b0, 1'b1);
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b1);
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b0);
        send_px(24'hAABBCC, 1'b0, 1'b1);
        send_px(24'h112233, 1'b1, 1'b1);
        wait_words(10, ok);
        applied++;
        if (q.size() != 10) begin
            miscompares++;
            $display("FAIL short_count: got %0d words required 10", q.size());
        end
        for (int i = 0; i < 10; i++) begin
            got = (i < q.size()) ? q[i] : 38'h0;
            applied++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL short_word%0d: got %010h required %010h", i, got, exp[i]);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_full_line();
        logic [23:0] p;
        logic [37:0] exp;
        logic [37:0] got;
        bit ok;
        int bad;
        q.delete();
        mb.delete();
        out_stream_tready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            p = {8'(i * 7 + 3), 8'(i >> 2), 8'(i)};
            model_px(p);
            send_px(p, (i == 0), (i == 1023));
        end
        wait_words(768, ok);
        applied++;
        if (q.size() != 768) begin
            miscompares++;
            $display("FAIL line_count: got %0d words required 768", q.size());
        end
        bad = 0;
        for (int k = 0; k < 768; k++) begin
            exp = {(k == 0), (k == 767), 4'hF, mb[4*k+3], mb[4*k+2], mb[4*k+1], mb[4*k]};
            got = (k < q.size()) ? q[k] : 38'h0;
            applied++;
            if (got !== exp) begin
                miscompares++;
                bad++;
                if (bad <= 8) $display("FAIL line_word%0d: got %010h required %010h", k, got, exp);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure();
        logic [23:0] px [8];
        logic [37:0] exp;
        logic [37:0] got;
        logic [31:0] first_data;
        bit have_first;
        bit stable;
        bit ok;
        bit sent;
        int k;
        px[0] = 24'h010203; px[1] = 24'h040506; px[2] = 24'h070809; px[3] = 24'h0A0B0C;
        px[4] = 24'hF0E0D0; px[5] = 24'hC0B0A0; px[6] = 24'h908070; px[7] = 24'h605040;
        q.delete();
        mb.delete();
        for (int i = 0; i < 8; i++) model_px(px[i]);
        out_stream_tready = 1'b0;
        sent = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_px(px[i], 1'b0, 1'b0);
                sent = 1'b1;
            end
        join_none
        have_first = 1'b0;
        stable = 1'b1;
        first_data = 32'h0;
        repeat (20) begin
            @(negedge aclk);
            if (out_stream_tvalid) begin
                if (!have_first) begin
                    first_data = out_stream_tdata;
                    have_first = 1'b1;
                end else if (out_stream_tdata !== first_data) begin
                    stable = 1'b0;
                end
            end
        end
        applied++;
        if (in_stream_ready !== 1'b0 || out_stream_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold_state: ready=%0b tvalid=%0b required 0 1", in_stream_ready, out_stream_tvalid);
        end
        applied++;
        if (!stable || out_stream_tdata !== {mb[3], mb[2], mb[1], mb[0]}) begin
            miscompares++;
            $display("FAIL bp_tdata_stable: got %08h stable=%0b required %08h stable=1",
                     out_stream_tdata, stable, {mb[3], mb[2], mb[1], mb[0]});
        end
        applied++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_no_pop: got %0d words popped required 0", q.size());
        end
        @(posedge aclk);
        #1;
        out_stream_tready = 1'b1;
        k = 0;
        while (!sent && k < 400) begin
            @(posedge aclk);
            k++;
        end
        applied++;
        if (!sent) begin
            miscompares++;
            $display("FAIL bp_sender_done: got 0 required 1");
        end
        #1;
        wait_words(6, ok);
        applied++;
        if (q.size() != 6) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words required 6", q.size());
        end
        for (int i = 0; i < 6; i++) begin
            exp = {1'b0, 1'b0, 4'hF, mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
            got = (i < q.size()) ? q[i] : 38'h0;
            applied++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %010h required %010h", i, got, exp);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_sof_realign();
        logic [37:0] exp [4];
        logic [37:0] got;
        bit ok;
        exp[0] = {1'b0, 1'b0, 4'hF, 32'h66112233};
        exp[1] = {1'b1, 1'b0, 4'hF, 32'h33AABBCC};
        exp[2] = {1'b0, 1'b0, 4'hF, 32'h55661122};
        exp[3] = {1'b0, 1'b0, 4'hF, 32'h77889944};
        q.delete();
        out_stream_tready = 1'b1;
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        // Phase is 2 here: residue 4455 must be discarded.
        send_px(24'hAABBCC, 1'b1, 1'b0);
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b0);
        wait_words(4, ok);
        applied++;
        if (q.size() != 4) begin
            miscompares++;
            $display("FAIL sof_count: got %0d words required 4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 38'h0;
            applied++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL sof_word%0d: got %010h required %010h", i, got, exp[i]);
            end
        end
`ifdef PACKER_STATS_EN
        applied++;
        if (align_err_count !== 16'd1 || frame_count !== 16'(sof_cnt)) begin
            miscompares++;
            $display("FAIL sof_stats: align=%0d frame=%0d required 1 %0d", align_err_count, frame_count, sof_cnt);
        end
`endif
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_midword();
        logic [37:0] exp [3];
        logic [37:0] got;
        bit ok;
        exp[0] = {1'b1, 1'b0, 4'hF, 32'h66112233};
        exp[1] = {1'b0, 1'b0, 4'hF, 32'h88994455};
        exp[2] = {1'b0, 1'b0, 4'hF, 32'hAABBCC77};
        out_stream_tready = 1'b0;
        send_px(24'h112233, 1'b0, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b0);
        // FIFO holds words, residue holds one byte; assert reset between edges.
        #2;
        aresetn = 1'b1;
        #1;
        applied++;
        if ({out_stream_tvalid, out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, in_stream_ready} !== 39'd0) begin
            miscompares++;
            $display("FAIL midword_reset_outputs: valid=%0b data=%08h keep=%h last=%0b user=%0b ready=%0b required all 0",
                     out_stream_tvalid, out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser, in_stream_ready);
        end
`ifdef PACKER_STATS_EN
        applied++;
        if (frame_count !== 16'd0 || align_err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL midword_reset_stats: frame=%0d align=%0d required 0 0", frame_count, align_err_count);
        end
`endif
        sof_cnt = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        out_stream_tready = 1'b1;
        q.delete();
        send_px(24'h112233, 1'b1, 1'b0);
        send_px(24'h445566, 1'b0, 1'b0);
        send_px(24'h778899, 1'b0, 1'b0);
        send_px(24'hAABBCC, 1'b0, 1'b0);
        wait_words(3, ok);
        applied++;
        if (q.size() != 3) begin
            miscompares++;
            $display("FAIL midword_count: got %0d words required 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 38'h0;
            applied++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL midword_word%0d: got %010h required %010h", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        applied = 0;
        miscompares = 0;
        sof_cnt = 0;
        aresetn = 1'b1;
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
        valid = 1'b0;
        sof = 1'b0;
        eol = 1'b0;
        out_stream_tready = 1'b0;

        test_reset();
        test_four_pixels();
        test_short_lines();
        test_full_line();
        test_backpressure();
        test_sof_realign();
        test_reset_midword();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
